// File: rtl/rom_burst_reader.sv
// Burst reader for a 1-cycle-latency synchronous ROM: fetches len words from
// base_addr into a 2-entry FIFO and streams them out on a valid/ready interface.
module rom_burst_reader #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned LEN_WIDTH  = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_rdata,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_FLUSH
  } state_t;

  state_t                state_q;
  logic                  busy_q;
  logic                  done_q;
  logic [ADDR_WIDTH-1:0] rom_addr_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  issue_cnt_q;
  logic                  inflight_q;
  logic                  inflight_last_q;

  // FIFO: head entry drives the stream directly, second entry is the skid slot
  logic [DATA_WIDTH-1:0] head_data_q, head_data_d;
  logic                  head_valid_q, head_valid_d;
  logic                  head_last_q, head_last_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                  skid_valid_q, skid_valid_d;
  logic                  skid_last_q, skid_last_d;

  logic                  pop;
  logic                  push;
  logic                  issue;
  logic                  issue_last;
  logic [2:0]            occupancy;
  logic [LEN_WIDTH-1:0]  len_clamped;

  always_comb begin
    pop         = head_valid_q & out_ready;
    push        = inflight_q;
    occupancy   = {2'b00, head_valid_q} + {2'b00, skid_valid_q} + {2'b00, inflight_q};
    issue       = (state_q == S_FETCH) && (occupancy < (3'd2 + {2'b00, pop}));
    issue_last  = (issue_cnt_q == (len_q - LEN_WIDTH'(1)));
    len_clamped = (len > MAX_LEN) ? MAX_LEN : len;
  end

  always_comb begin
    head_data_d  = head_data_q;
    head_valid_d = head_valid_q;
    head_last_d  = head_last_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;
    skid_last_d  = skid_last_q;
    if (pop) begin
      if (skid_valid_q) begin
        head_data_d  = skid_data_q;
        head_valid_d = 1'b1;
        head_last_d  = skid_last_q;
        skid_data_d  = push ? rom_rdata : skid_data_q;
        skid_valid_d = push;
        skid_last_d  = push & inflight_last_q;
      end else begin
        head_data_d  = push ? rom_rdata : head_data_q;
        head_valid_d = push;
        head_last_d  = push & inflight_last_q;
      end
    end else if (push) begin
      // issue throttling guarantees a free slot whenever a word returns
      if (!head_valid_q) begin
        head_data_d  = rom_rdata;
        head_valid_d = 1'b1;
        head_last_d  = inflight_last_q;
      end else begin
        skid_data_d  = rom_rdata;
        skid_valid_d = 1'b1;
        skid_last_d  = inflight_last_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      rom_addr_q      <= '0;
      len_q           <= '0;
      issue_cnt_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      head_data_q     <= '0;
      head_valid_q    <= 1'b0;
      head_last_q     <= 1'b0;
      skid_data_q     <= '0;
      skid_valid_q    <= 1'b0;
      skid_last_q     <= 1'b0;
    end else begin
      done_q       <= 1'b0;
      head_data_q  <= head_data_d;
      head_valid_q <= head_valid_d;
      head_last_q  <= head_last_d;
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
      skid_last_q  <= skid_last_d;
      inflight_q   <= issue;
      if (issue) begin
        inflight_last_q <= issue_last;
        rom_addr_q      <= rom_addr_q + ADDR_WIDTH'(1);
        issue_cnt_q     <= issue_cnt_q + LEN_WIDTH'(1);
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (len_clamped != '0) begin
              state_q     <= S_FETCH;
              busy_q      <= 1'b1;
              rom_addr_q  <= base_addr;
              len_q       <= len_clamped;
              issue_cnt_q <= '0;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          if (issue && issue_last) state_q <= S_FLUSH;
        end
        S_FLUSH: begin
          // the tagged last word is the final one written, so its transfer
          // leaves the FIFO empty with nothing in flight
          if (pop && head_last_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rom_addr  = rom_addr_q;
  assign out_data  = head_data_q;
  assign out_valid = head_valid_q;
  assign out_last  = head_last_q;

endmodule

// File: tb/tb_rom_burst_reader.sv
// Directed bench for rom_burst_reader with a ROM model holding ROM[i] = i*0x010101.
module tb_rom_burst_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [8:0]  len = '0;
  logic        busy, done, out_valid, out_last;
  logic        out_ready = 1'b0;
  logic [7:0]  rom_addr;
  logic [23:0] rom_rdata;
  logic [23:0] out_data;

  int tests = 0;
  int fails = 0;

  rom_burst_reader #(.ADDR_WIDTH(8), .DATA_WIDTH(24), .LEN_WIDTH(9)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_rdata <= {rom_addr, rom_addr, rom_addr};

  function automatic logic [23:0] w(input logic [7:0] a);
    return {a, a, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(negedge clk);
  endtask

  task automatic burst_start(input logic [7:0] b, input logic [8:0] l);
    base_addr = b;
    len       = l;
    start     = 1'b1;
    cyc();
    start     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int idx;
    bit stalled;
    logic [23:0] prev;
    logic pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

    // reset and idle
    cyc(); cyc();
    rst = 1'b0;
    repeat (5) cyc();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_addr", rom_addr, 0);

    // full rate
    out_ready = 1'b1;
    burst_start(8'h10, 9'd4);
    chk("fr_addr_c1", rom_addr, 8'h10);
    chk("fr_busy_c1", busy, 1);
    cyc();
    chk("fr_valid_c2", out_valid, 0);
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk("fr_valid", out_valid, 1);
      chk("fr_data", out_data, w(8'(8'h10 + i)));
      chk("fr_last", out_last, (i == 3) ? 1 : 0);
      chk("fr_busy", busy, 1);
      cyc();
    end
    chk("fr_done_c7", done, 1);
    chk("fr_busy_c7", busy, 0);
    chk("fr_valid_c7", out_valid, 0);
    cyc();
    chk("fr_done_c8", done, 0);

    // backpressure with ready pattern 1,0,0,1
    burst_start(8'h20, 9'd6);
    idx = 0;
    stalled = 1'b0;
    prev = '0;
    for (int k = 0; k < 80 && !(idx == 6 && !busy); k++) begin
      if (stalled) begin
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_data", out_data, prev);
      end
      out_ready = pat[k % 4];
      if (out_valid) begin
        if (out_ready) begin
          chk("bp_data", out_data, w(8'(8'h20 + idx)));
          chk("bp_last", out_last, (idx == 5) ? 1 : 0);
          idx++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          prev = out_data;
        end
      end else begin
        stalled = 1'b0;
      end
      cyc();
    end
    chk("bp_count", idx, 6);
    chk("bp_done", done, 1);
    chk("bp_busy", busy, 0);
    out_ready = 1'b1;
    cyc();

    // address wrap
    burst_start(8'hFE, 9'd4);
    for (int i = 0; i < 6; i++) begin
      if (i < 4) chk("wr_addr", rom_addr, 8'(8'hFE + i));
      if (i >= 2) begin
        chk("wr_data", out_data, w(8'(8'hFE + i - 2)));
        chk("wr_last", out_last, (i == 5) ? 1 : 0);
      end
      cyc();
    end
    chk("wr_done", done, 1);
    cyc();

    // empty burst, then a start accepted in its done cycle
    burst_start(8'h77, 9'd0);
    chk("em_done", done, 1);
    chk("em_busy", busy, 0);
    chk("em_valid", out_valid, 0);
    chk("em_addr", rom_addr, 8'h02);
    burst_start(8'h05, 9'd1);
    chk("b2b_done", done, 0);
    chk("b2b_busy", busy, 1);
    chk("b2b_addr", rom_addr, 8'h05);
    cyc();
    chk("b2b_valid_c2", out_valid, 0);
    cyc();
    chk("b2b_data", out_data, w(8'h05));
    chk("b2b_last", out_last, 1);
    cyc();
    chk("b2b_done_end", done, 1);
    chk("b2b_busy_end", busy, 0);
    cyc();

    // start and input changes while busy are ignored
    burst_start(8'h30, 9'd3);
    base_addr = 8'h80; len = 9'd5; start = 1'b1;
    chk("ig_addr_c1", rom_addr, 8'h30);
    cyc();
    start = 1'b0; base_addr = 8'h90; len = 9'd7;
    chk("ig_addr_c2", rom_addr, 8'h31);
    cyc();
    for (int i = 0; i < 3; i++) begin
      chk("ig_data", out_data, w(8'(8'h30 + i)));
      chk("ig_last", out_last, (i == 2) ? 1 : 0);
      cyc();
    end
    chk("ig_done", done, 1);
    cyc();
    chk("ig_busy_after", busy, 0);
    chk("ig_valid_after", out_valid, 0);
    chk("ig_done_after", done, 0);

    // asynchronous abort mid-burst
    out_ready = 1'b0;
    burst_start(8'h40, 9'd8);
    cyc(); cyc(); cyc();
    chk("ab_valid_pre", out_valid, 1);
    chk("ab_data_pre", out_data, w(8'h40));
    #2 rst = 1'b1;
    #1;
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 0);
    chk("ab_valid", out_valid, 0);
    chk("ab_last", out_last, 0);
    chk("ab_addr", rom_addr, 0);
    chk("ab_data", out_data, 0);
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("ab_no_done", done, 0);
      chk("ab_no_valid", out_valid, 0);
    end

    // new burst after reset
    out_ready = 1'b1;
    burst_start(8'h50, 9'd2);
    chk("nb_addr", rom_addr, 8'h50);
    cyc(); cyc();
    chk("nb_data0", out_data, w(8'h50));
    chk("nb_last0", out_last, 0);
    cyc();
    chk("nb_data1", out_data, w(8'h51));
    chk("nb_last1", out_last, 1);
    cyc();
    chk("nb_done", done, 1);
    chk("nb_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
